// File: rtl/simon_cfg_pkg.sv
// Shared types and constants for the SIMON key-config AXI4-Lite loader.
package simon_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_START,
    S_START_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_FINISH,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RESP    = 2'd1,
    ERR_VERIFY  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam int unsigned START_ADDR    = 8;
  localparam int unsigned AXI_RESP_OKAY = 0;

  function automatic int unsigned nwords(input int unsigned keylen_bytes);
    return keylen_bytes / 4;
  endfunction

  localparam int unsigned NWORDS = nwords(32);

endpackage

// File: rtl/simon_cfg_aw_w_issuer.sv
// Drives the AW/W valid pair for one write; each valid drops on its own
// handshake and o_done flags the cycle in which both have completed.
module simon_cfg_aw_w_issuer (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_awready,
  input  logic i_wready,
  output logic o_awvalid,
  output logic o_wvalid,
  output logic o_done
);

  logic r_aw_done;
  logic r_w_done;
  logic w_aw_hs;
  logic w_w_hs;

  assign o_awvalid = i_active && !r_aw_done;
  assign o_wvalid  = i_active && !r_w_done;
  assign w_aw_hs   = o_awvalid && i_awready;
  assign w_w_hs    = o_wvalid && i_wready;
  assign o_done    = i_active && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // Dropping i_active (e.g. on timeout) clears both flags, withdrawing the valids.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (!i_active || o_done) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/simon_cfg_loader.sv
// AXI4-Lite initiator writing a SIMON key into the key-config block, with
// optional start-override write, read-back verify and per-state timeout.
module simon_cfg_loader #(
  parameter int unsigned KEYLEN_BYTES   = 32,
  parameter int unsigned CFG_DATA_WIDTH = 32,
  parameter int unsigned CFG_ADDR_WIDTH = 32,
  parameter int unsigned CFG_PROT_WIDTH = 1,
  parameter int unsigned CFG_RESP_WIDTH = 2,
  parameter int unsigned CFG_STRB_WIDTH = 4,
  parameter int unsigned START_OVERRIDE = 0,
  parameter int unsigned VERIFY_EN      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  input  logic [KEYLEN_BYTES*8-1:0] load_key,
  output logic                      load_ready,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [CFG_ADDR_WIDTH-1:0] simon_cfg_awaddr,
  output logic [CFG_PROT_WIDTH-1:0] simon_cfg_awprot,
  output logic                      simon_cfg_awvalid,
  input  logic                      simon_cfg_awready,
  output logic [CFG_DATA_WIDTH-1:0] simon_cfg_wdata,
  output logic [CFG_STRB_WIDTH-1:0] simon_cfg_wstrb,
  output logic                      simon_cfg_wvalid,
  input  logic                      simon_cfg_wready,
  input  logic [CFG_RESP_WIDTH-1:0] simon_cfg_bresp,
  input  logic                      simon_cfg_bvalid,
  output logic                      simon_cfg_bready,
  output logic [CFG_ADDR_WIDTH-1:0] simon_cfg_araddr,
  output logic [CFG_PROT_WIDTH-1:0] simon_cfg_arprot,
  output logic                      simon_cfg_arvalid,
  input  logic                      simon_cfg_arready,
  input  logic [CFG_DATA_WIDTH-1:0] simon_cfg_rdata,
  input  logic [CFG_RESP_WIDTH-1:0] simon_cfg_rresp,
  input  logic                      simon_cfg_rvalid,
  output logic                      simon_cfg_rready
);

  import simon_cfg_pkg::*;

  localparam int unsigned NW   = nwords(KEYLEN_BYTES);
  localparam int unsigned IDXW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned TCW  = $clog2(TIMEOUT_CYCLES + 1);

  state_e                      r_state;
  state_e                      w_state_nxt;
  state_e                      w_after_key;
  state_e                      w_after_start;
  err_code_e                   r_err_code;
  err_code_e                   w_code_nxt;
  logic                        r_error;
  logic [KEYLEN_BYTES*8-1:0]   r_key;
  logic [IDXW-1:0]             r_idx;
  logic [TCW-1:0]              r_tcnt;
  logic [CFG_DATA_WIDTH-1:0]   w_key_word;
  logic                        w_last;
  logic                        w_accept;
  logic                        w_to;
  logic                        w_iss_active;
  logic                        w_iss_done;

  assign w_key_word = r_key[int'(r_idx) * CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
  assign w_last     = (r_idx == IDXW'(NW - 1));
  assign w_accept   = (r_state == S_IDLE) && load_valid;
  assign w_to       = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

  simon_cfg_aw_w_issuer u_issuer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_active  (w_iss_active),
    .i_awready (simon_cfg_awready),
    .i_wready  (simon_cfg_wready),
    .o_awvalid (simon_cfg_awvalid),
    .o_wvalid  (simon_cfg_wvalid),
    .o_done    (w_iss_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_after_start = (VERIFY_EN != 0) ? S_RD_ADDR : S_FINISH;
    w_after_key   = (START_OVERRIDE != 0) ? S_START : w_after_start;
    w_state_nxt   = r_state;
    w_code_nxt    = ERR_NONE;
    unique case (r_state)
      S_IDLE: if (load_valid) w_state_nxt = S_WR;
      S_WR, S_START: begin
        if (w_iss_done) w_state_nxt = (r_state == S_WR) ? S_WR_RESP : S_START_RESP;
        else if (w_to) begin
          w_state_nxt = S_FAULT;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
      S_WR_RESP, S_START_RESP: begin
        if (simon_cfg_bvalid) begin
          if (simon_cfg_bresp != CFG_RESP_WIDTH'(AXI_RESP_OKAY)) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = ERR_RESP;
          end else if (r_state == S_START_RESP) w_state_nxt = w_after_start;
          else if (w_last)                      w_state_nxt = w_after_key;
          else                                  w_state_nxt = S_WR;
        end else if (w_to) begin
          w_state_nxt = S_FAULT;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
      S_RD_ADDR: begin
        if (simon_cfg_arready) w_state_nxt = S_RD_DATA;
        else if (w_to) begin
          w_state_nxt = S_FAULT;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
      S_RD_DATA: begin
        if (simon_cfg_rvalid) begin
          if (simon_cfg_rresp != CFG_RESP_WIDTH'(AXI_RESP_OKAY)) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = ERR_RESP;
          end else if (simon_cfg_rdata != w_key_word) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = ERR_VERIFY;
          end else w_state_nxt = w_last ? S_FINISH : S_RD_ADDR;
        end else if (w_to) begin
          w_state_nxt = S_FAULT;
          w_code_nxt  = ERR_TIMEOUT;
        end
      end
      S_FINISH, S_FAULT: w_state_nxt = S_IDLE;
      default:           w_state_nxt = S_IDLE;
    endcase
  end

  // Word index is reused by the read pass, so it rewinds when entering it from a write response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key      <= '0;
      r_idx      <= '0;
      r_tcnt     <= '0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_tcnt <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_tcnt + 1'b1;
      if (w_accept) begin
        r_key      <= load_key;
        r_idx      <= '0;
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
      end else if (w_state_nxt == S_FAULT) begin
        r_error    <= 1'b1;
        r_err_code <= w_code_nxt;
      end else if ((r_state == S_WR_RESP && w_state_nxt == S_WR) ||
                   (r_state == S_RD_DATA && w_state_nxt == S_RD_ADDR)) begin
        r_idx <= r_idx + 1'b1;
      end else if (w_state_nxt == S_RD_ADDR) begin
        r_idx <= '0;
      end
    end
  end

  always_comb begin
    load_ready        = (r_state == S_IDLE);
    done              = (r_state == S_FINISH) || (r_state == S_FAULT);
    w_iss_active      = 1'b0;
    simon_cfg_awaddr  = '0;
    simon_cfg_wdata   = '0;
    simon_cfg_araddr  = '0;
    simon_cfg_bready  = 1'b0;
    simon_cfg_arvalid = 1'b0;
    simon_cfg_rready  = 1'b0;
    unique case (r_state)
      S_WR: begin
        w_iss_active     = 1'b1;
        simon_cfg_awaddr = CFG_ADDR_WIDTH'(r_idx);
        simon_cfg_wdata  = w_key_word;
      end
      S_START: begin
        w_iss_active     = 1'b1;
        simon_cfg_awaddr = CFG_ADDR_WIDTH'(START_ADDR);
      end
      S_WR_RESP, S_START_RESP: simon_cfg_bready = 1'b1;
      S_RD_ADDR: begin
        simon_cfg_arvalid = 1'b1;
        simon_cfg_araddr  = CFG_ADDR_WIDTH'(r_idx);
      end
      S_RD_DATA: simon_cfg_rready = 1'b1;
      default: ;
    endcase
  end

  assign error            = r_error;
  assign err_code         = r_err_code;
  assign simon_cfg_awprot = '0;
  assign simon_cfg_arprot = '0;
  assign simon_cfg_wstrb  = '1;

endmodule
